// File: rtl/serial_tx_buff_if.sv
// Load/serial handshake bundle for serial_tx_buff.
// master drives the word and strobes; slave is the transmitter.
interface serial_tx_buff_if #(
    parameter int NDATA = 128
);
    localparam int NDATA_LOG = $clog2(NDATA);

    logic [NDATA-1:0]     din;
    logic                 load;
    logic                 ready;
    logic                 ena;
    logic                 dout;
    logic [NDATA_LOG-1:0] cntout;
    logic                 busy;
    logic                 done;

    modport master (
        output din, load, ena,
        input  ready, dout, cntout, busy, done
    );

    modport slave (
        input  din, load, ena,
        output ready, dout, cntout, busy, done
    );
endinterface

// File: rtl/serial_tx_buff.sv
// Parallel-in/serial-out transmit buffer, MSB first, down-counting cntout.
// Optional trailing even-parity bit with `define SERIAL_TX_PARITY_EN.
module serial_tx_buff #(
    parameter int NDATA = 128
) (
    input logic              clk,
    input logic              rst,
    serial_tx_buff_if.slave  bus
);
    localparam int NDATA_LOG = $clog2(NDATA);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t               state;
    logic [NDATA-1:0]     shreg;
    logic [NDATA_LOG-1:0] cnt;
    logic                 ready;
    logic                 busy;
    logic                 done;
`ifdef SERIAL_TX_PARITY_EN
    logic                 par;
`endif

    // The parity bit is parked in the shreg MSB so dout stays a pure register tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg <= bus.din;
                        cnt   <= NDATA_LOG'(NDATA - 1);
                        state <= SHIFT;
                        ready <= 1'b0;
                        busy  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= ^bus.din;
`endif
                    end
                end
                SHIFT: begin
                    if (bus.ena) begin
                        if (cnt != '0) begin
                            shreg <= shreg << 1;
                            cnt   <= cnt - NDATA_LOG'(1);
                        end else begin
`ifdef SERIAL_TX_PARITY_EN
                            shreg <= {par, {(NDATA-1){1'b0}}};
                            state <= PAR;
`else
                            shreg <= '0;
                            state <= IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PAR: begin
                    if (bus.ena) begin
                        shreg <= '0;
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout   = shreg[NDATA-1];
    assign bus.cntout = cnt;
    assign bus.ready  = ready;
    assign bus.busy   = busy;
    assign bus.done   = done;
endmodule

// File: tb/tb_serial_tx_buff.sv
// Directed bench for serial_tx_buff at NDATA=8.
// Parity frames are checked when SERIAL_TX_PARITY_EN is defined.
module tb_serial_tx_buff;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    serial_tx_buff_if #(.NDATA(N)) bus ();

    serial_tx_buff #(.NDATA(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one cycle after the load edge, with ena already chosen by caller.
    task automatic frame(input logic [7:0] w, input bit stall,
                         input string tag);
        for (int k = N - 1; k >= 0; k--) begin
            check({tag, "_dout"}, 32'(bus.dout), 32'(w[k]));
            check({tag, "_cnt"}, 32'(bus.cntout), 32'(k));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_done"}, 32'(bus.done), 32'd0);
            if (stall) begin
                bus.ena = 1'b0;
                repeat (2) begin
                    step();
                    check({tag, "_hold_dout"}, 32'(bus.dout), 32'(w[k]));
                    check({tag, "_hold_cnt"}, 32'(bus.cntout), 32'(k));
                end
            end
            bus.ena = 1'b1;
            step();
        end
`ifdef SERIAL_TX_PARITY_EN
        check({tag, "_par_dout"}, 32'(bus.dout), 32'(^w));
        check({tag, "_par_cnt"}, 32'(bus.cntout), 32'd0);
        check({tag, "_par_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_par_done"}, 32'(bus.done), 32'd0);
        step();
`endif
        check({tag, "_end_done"}, 32'(bus.done), 32'd1);
        check({tag, "_end_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_dout"}, 32'(bus.dout), 32'd0);
        check({tag, "_end_cnt"}, 32'(bus.cntout), 32'd0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        bus.din  = '0;
        bus.load = 1'b0;
        bus.ena  = 1'b0;

        #2 rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_cnt", 32'(bus.cntout), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("idle_ready", 32'(bus.ready), 32'd1);

        // Basic frame; ena alongside load must not consume a bit.
        bus.din  = 8'hA5;
        bus.load = 1'b1;
        bus.ena  = 1'b1;
        step();
        bus.load = 1'b0;
        check("load_cnt", 32'(bus.cntout), 32'd7);
        check("load_ready", 32'(bus.ready), 32'd0);
        frame(8'hA5, 1'b0, "basic");
        bus.ena = 1'b0;
        step();
        check("basic_after_done", 32'(bus.done), 32'd0);
        check("basic_after_ready", 32'(bus.ready), 32'd1);

        // Stalled frame.
        bus.din  = 8'hC3;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.ena  = 1'b1;
        frame(8'hC3, 1'b1, "stall");
        bus.ena = 1'b0;
        step();
        check("stall_after_done", 32'(bus.done), 32'd0);

        // Load held through a frame, then accepted back-to-back.
        bus.din  = 8'h0F;
        bus.load = 1'b1;
        step();
        bus.din = 8'hFF;
        bus.ena = 1'b1;
        frame(8'h0F, 1'b0, "busyload");
        step();
        bus.load = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_ready", 32'(bus.ready), 32'd0);
        check("b2b_cnt", 32'(bus.cntout), 32'd7);
        frame(8'hFF, 1'b0, "b2b");
        bus.ena = 1'b0;
        step();

        // Reset mid-frame.
        bus.din  = 8'hFF;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.ena  = 1'b1;
        repeat (3) step();
        check("mid_cnt", 32'(bus.cntout), 32'd4);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        check("mid_rst_cnt", 32'(bus.cntout), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("mid_post_done", 32'(bus.done), 32'd0);
        check("mid_post_busy", 32'(bus.busy), 32'd0);
        bus.ena  = 1'b0;
        bus.din  = 8'h81;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.ena  = 1'b1;
        frame(8'h81, 1'b0, "post_rst");
        bus.ena = 1'b0;
        step();

`ifdef SERIAL_TX_PARITY_EN
        bus.din  = 8'h07;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.ena  = 1'b1;
        frame(8'h07, 1'b0, "par07");
        bus.ena = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_tx_buff.md
Name: serial_tx_buff

Overview:
Parallel-in/serial-out transmit buffer; the transmit end of the project's serial link.
- Accepts an NDATA-bit word via a valid/ready load handshake.
- Shifts the word out MSB-first, one bit per clock where ena=1.
- Exports a down-counting bit index, cntout, that matches the receive-side cntin convention: cntout==0 marks the final bit of a frame.

Parameters:
- NDATA, 128, frame width in bits; must be ≥2.
- NDATA_LOG, $clog2(NDATA), localparam; width of cntout.

Ports:
- clk    input   1        clock, rising edge
- rst    input   1        reset, asynchronous, active-low
- din    input   NDATA    parallel word to transmit
- load   input   1        din valid; accepted when load & ready at a rising edge
- ready  output  1        buffer idle, can accept load
- ena    input   1        bit strobe; each rising edge with ena=1 consumes one bit
- dout   output  1        serial data, MSB first
- cntout output  NDATA_LOG  index of bit currently on dout; counts NDATA-1 down to 0
- busy   output  1        frame in progress
- done   output  1        one-cycle pulse after the last bit is consumed

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, cntout=0, ready=1, busy=0, done=0, dout=0. Takes effect immediately, including mid-frame; the frame is abandoned and not resumed.
- dout is continuously equal to shreg[NDATA-1]. It is register-driven; there is no combinational path from any input.
- States: IDLE, SHIFT, PAR (PAR exists only with the optional feature).
- IDLE:
  - ready=1, busy=0.
  - On edge with load=1: shreg<=din, cntout<=NDATA-1, go to SHIFT.
  - ena is ignored in IDLE, including when asserted in the same cycle as load.
- SHIFT:
  - ready=0, busy=1.
  - Edge with ena=1 and cntout!=0: shreg<=shreg<<1 (LSB filled with 0), cntout<=cntout-1.
  - Edge with ena=1 and cntout==0: go to IDLE (or PAR), shreg<=0, cntout stays 0, done<=1.
  - ena=0: shreg, cntout and dout hold (stall), unlimited length.
- done is registered and high for exactly the one cycle following the final consume. ready rises in that same cycle.
- A new load is therefore accepted at the earliest one cycle after the final consume. A load asserted while ready=0 is ignored and not queued.
- Bit k of the word (k = NDATA-1 down to 0) is on dout while cntout==k.
- Frame length is exactly NDATA ena-qualified edges.
- cntout is not modular: it never wraps below 0.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - On load, an even-parity bit p = ^din is registered.
  - The final SHIFT consume goes to PAR instead of IDLE (done not yet asserted).
  - In PAR: dout=p, cntout=0, busy=1, ready=0.
  - The next edge with ena=1 goes to IDLE and pulses done.
  - Frame = NDATA+1 bits.
- Undefined: no PAR state and no parity register; the frame is exactly NDATA bits.

Test Plan (NDATA=8 unless noted):
1. Reset values: assert rst=0 mid-run -> ready=1, busy=0, done=0, dout=0, cntout=0 immediately, before the next clk edge.
2. Basic frame: load 8'hA5, ena held 1 from the next cycle -> dout = 1,0,1,0,0,1,0,1 with cntout 7..0; done high exactly one cycle after the 8th consume; ready=1 that same cycle.
3. Stall: 8'hC3 with ena toggling 1,0,0,1,... -> dout and cntout hold on every ena=0 cycle; bit order 1,1,0,0,0,0,1,1 unchanged; done only after 8 ena=1 edges.
4. Load while busy and back-to-back: load 8'h0F, assert load=1 with din=8'hFF on every cycle of the frame -> the 8'hFF loads are ignored during the frame; transmitted bits are 0,0,0,0,1,1,1,1; 8'hFF is accepted in the done cycle; the second frame starts the cycle after.
5. Reset mid-frame: load 8'hFF, reset after 3 consumes -> state IDLE, no done pulse; a subsequent load of 8'h81 transmits a clean 1,0,0,0,0,0,0,1.
6. SERIAL_TX_PARITY_EN: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1; cntout=0 during both the 8th and 9th bits; done follows the 9th consume.
